// File: rtl/cpu_multicycle.sv
`timescale 1ns/1ps
// cpu_multicycle: parametrised fetch/execute CPU with a stallable
// instruction bus, hardware return stack, carry/zero and sticky error flags.
//
// Fetch handshake: instr_req is high for the whole of FETCH. The word on
// instruction is consumed on the first enabled clock edge where
// instr_valid is high. Memory may hold instr_valid low for any number of
// cycles, and instr_valid has no meaning while instr_req is low.
module cpu_multicycle #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int NUM_REGS    = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  output logic              instr_req,
  input  logic              instr_valid,
  input  logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instruction_pointer,
  input  logic [DATA_W-1:0] din,
  input  logic [3:0]        gpi,
  output logic [DATA_W-1:0] reg_dout,
  output logic [DATA_W-1:0] reg_gout,
  output logic [7:0]        reg_flag,
  output logic              halted,
  output logic [1:0]        state_dbg
);

  localparam int RIDX_W    = $clog2(NUM_REGS);
  localparam int SP_W      = $clog2(STACK_DEPTH + 1);
  localparam int STK_IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int STK_SIZE  = 1 << STK_IDX_W;
  localparam logic [7:0] NREGS8 = 8'(NUM_REGS);

  localparam logic [3:0] OP_MOV  = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7,  OP_JMP = 4'd8,  OP_BZ  = 4'd9;
  localparam logic [3:0] OP_BNZ  = 4'd10, OP_CALL = 4'd11, OP_RET = 4'd12;
  localparam logic [3:0] OP_ILL0 = 4'd13, OP_ILL1 = 4'd14, OP_HALT = 4'd15;

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_HALT = 2'd2} state_t;
  state_t state;

  // Latched instruction fields; bits [25:24] are don't-care
  logic [3:0]        op;
  logic              a_reg, b_reg;
  logic [7:0]        arg1, arg2, tgt8;

  logic [DATA_W-1:0] regs  [0:NUM_REGS-1];
  logic [ADDR_W-1:0] stack [0:STK_SIZE-1];
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] pc;
  logic              flag_z, flag_c, flag_sovf, flag_sund, flag_ill;

  logic              unused_bits;
  assign unused_bits = ^instruction[25:24];

  // Operand source: register file, din, gpi, or zero for unmapped indices
  function automatic logic [DATA_W-1:0] read_op(input logic [7:0] idx);
    if (idx < NREGS8)      return regs[idx[RIDX_W-1:0]];
    else if (idx == 8'hFF) return din;
    else if (idx == 8'hFE) return DATA_W'(gpi);
    else                   return '0;
  endfunction

  logic [DATA_W-1:0] a_val, b_val, result;
  logic [DATA_W:0]   sum, diff;
  logic              carry, wr;
  logic [ADDR_W-1:0] pc_inc, pc_next, tgt;
  logic              push, pop, set_sovf, set_sund, set_ill;
  logic              stack_full, stack_empty;

  // Execute-stage datapath: ALU result, carry, next PC and stack actions
  always_comb begin
    a_val       = a_reg ? read_op(arg1) : DATA_W'(arg1);
    b_val       = b_reg ? read_op(arg2) : DATA_W'(arg2);
    sum         = {1'b0, b_val} + {1'b0, a_val};
    diff        = {1'b0, b_val} - {1'b0, a_val};
    result      = '0;
    carry       = flag_c;
    wr          = 1'b0;
    pc_inc      = pc + ADDR_W'(1);
    tgt         = tgt8[ADDR_W-1:0];
    pc_next     = pc_inc;
    push        = 1'b0;
    pop         = 1'b0;
    set_sovf    = 1'b0;
    set_sund    = 1'b0;
    set_ill     = 1'b0;
    stack_full  = (sp == SP_W'(STACK_DEPTH));
    stack_empty = (sp == '0);
    case (op)
      OP_MOV: begin result = a_val;                wr = 1'b1; end
      OP_ADD: begin result = sum[DATA_W-1:0];  carry = sum[DATA_W];  wr = 1'b1; end
      OP_SUB: begin result = diff[DATA_W-1:0]; carry = diff[DATA_W]; wr = 1'b1; end
      OP_AND: begin result = b_val & a_val;        wr = 1'b1; end
      OP_OR:  begin result = b_val | a_val;        wr = 1'b1; end
      OP_XOR: begin result = b_val ^ a_val;        wr = 1'b1; end
      OP_SHL: begin result = {b_val[DATA_W-2:0], 1'b0}; carry = b_val[DATA_W-1]; wr = 1'b1; end
      OP_JMP: pc_next = tgt;
      OP_BZ:  if (a_val == '0) pc_next = tgt;
      OP_BNZ: if (a_val != '0) pc_next = tgt;
      OP_CALL: begin
        if (stack_full) set_sovf = 1'b1;
        else begin push = 1'b1; pc_next = tgt; end
      end
      OP_RET: begin
        if (stack_empty) set_sund = 1'b1;
        else begin pop = 1'b1; pc_next = stack[STK_IDX_W'(sp - 1'b1)]; end
      end
      OP_ILL0, OP_ILL1: set_ill = 1'b1;
      default: ;
    endcase
  end

  // Fetch/execute/halt FSM with all architectural state and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_FETCH;
      instr_req <= 1'b1;
      halted    <= 1'b0;
      pc        <= '0;
      op        <= '0;
      a_reg     <= 1'b0;
      b_reg     <= 1'b0;
      arg1      <= '0;
      arg2      <= '0;
      tgt8      <= '0;
      sp        <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_sovf <= 1'b0;
      flag_sund <= 1'b0;
      flag_ill  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      for (int i = 0; i < STK_SIZE; i++) stack[i] <= '0;
    end else if (enable) begin
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            op        <= instruction[31:28];
            a_reg     <= instruction[27];
            b_reg     <= instruction[26];
            arg1      <= instruction[23:16];
            arg2      <= instruction[15:8];
            tgt8      <= instruction[7:0];
            state     <= S_EXEC;
            instr_req <= 1'b0;
          end
        end
        S_EXEC: begin
          if (wr && (arg2 < NREGS8)) regs[arg2[RIDX_W-1:0]] <= result;
          if (wr) begin
            flag_z <= (result == '0);
            flag_c <= carry;
          end
          if (push) begin
            stack[STK_IDX_W'(sp)] <= pc_inc;
            sp <= sp + 1'b1;
          end
          if (pop) sp <= sp - 1'b1;
          flag_sovf <= flag_sovf | set_sovf;
          flag_sund <= flag_sund | set_sund;
          flag_ill  <= flag_ill | set_ill;
          pc        <= pc_next;
          if (op == OP_HALT) begin
            state     <= S_HALT;
            halted    <= 1'b1;
            instr_req <= 1'b0;
          end else begin
            state     <= S_FETCH;
            instr_req <= 1'b1;
          end
        end
        S_HALT: ;
        default: begin
          state     <= S_FETCH;
          instr_req <= 1'b1;
        end
      endcase
    end
  end

  assign instruction_pointer = pc;
  assign reg_dout  = regs[RIDX_W'(NUM_REGS - 1)];
  assign reg_gout  = regs[RIDX_W'(NUM_REGS - 2)];
  assign reg_flag  = {3'b000, flag_ill, flag_sund, flag_sovf, flag_c, flag_z};
  assign state_dbg = state;

endmodule

// File: tb/tb_cpu_multicycle.sv
`timescale 1ns/1ps
// Bench for cpu_multicycle: ISA-level reference model checked every cycle,
// plus hand-computed literal expectations for each directed program.
module tb_cpu_multicycle;

  localparam int DATA_W = 8, ADDR_W = 8, NUM_REGS = 16, STACK_DEPTH = 4;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic              instr_valid = 1'b0;
  logic [31:0]       instruction = '0;
  logic [DATA_W-1:0] din = 8'h5A;
  logic [3:0]        gpi = 4'hA;
  logic              instr_req, halted;
  logic [ADDR_W-1:0] instruction_pointer;
  logic [DATA_W-1:0] reg_dout, reg_gout;
  logic [7:0]        reg_flag;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  cpu_multicycle #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
                   .STACK_DEPTH(STACK_DEPTH)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .instr_req(instr_req),
    .instr_valid(instr_valid), .instruction(instruction),
    .instruction_pointer(instruction_pointer), .din(din), .gpi(gpi),
    .reg_dout(reg_dout), .reg_gout(reg_gout), .reg_flag(reg_flag),
    .halted(halted), .state_dbg(state_dbg)
  );

  logic [31:0] rom [0:255];
  int n_checks = 0;
  int n_pass = 0;
  bit cmp_on = 1'b1;

  // Instruction memory: presents the word at the current fetch address
  initial forever begin
    @(negedge clk);
    instruction = rom[instruction_pointer];
  end

  function automatic logic [31:0] enc(input int op, input bit ar, input bit br,
                                      input int a1, input int a2, input int t);
    return {4'(op), ar, br, 2'b00, 8'(a1), 8'(a2), 8'(t)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- ISA-level reference model ----------------
  int mpc, mphase;            // mphase: 0 waiting for fetch, 1 executing, 2 halted
  int mr [NUM_REGS];
  int mz, mc, msovf, msund, mill;
  int mstack [$];
  logic [31:0] mir;

  function automatic int m_read(input int idx);
    if (idx < NUM_REGS) return mr[idx];
    if (idx == 255) return int'(din);
    if (idx == 254) return int'(gpi);
    return 0;
  endfunction

  task automatic model_reset();
    mpc = 0; mphase = 0; mz = 0; mc = 0; msovf = 0; msund = 0; mill = 0;
    for (int i = 0; i < NUM_REGS; i++) mr[i] = 0;
    mstack.delete();
  endtask

  task automatic model_exec();
    int op, a1, a2, a, b, t, res, npc;
    bit wr;
    op = int'(mir[31:28]); a1 = int'(mir[23:16]); a2 = int'(mir[15:8]); t = int'(mir[7:0]);
    a = mir[27] ? m_read(a1) : a1;
    b = mir[26] ? m_read(a2) : a2;
    res = 0; wr = 0; npc = (mpc + 1) % 256;
    case (op)
      1: begin res = a; wr = 1; end
      2: begin res = a + b; mc = (res > 255); res = res % 256; wr = 1; end
      3: begin mc = (a > b); res = (b - a + 256) % 256; wr = 1; end
      4: begin res = b & a; wr = 1; end
      5: begin res = b | a; wr = 1; end
      6: begin res = b ^ a; wr = 1; end
      7: begin mc = (b >= 128); res = (b * 2) % 256; wr = 1; end
      8: npc = t;
      9: if (a == 0) npc = t;
      10: if (a != 0) npc = t;
      11: if (mstack.size() == STACK_DEPTH) msovf = 1;
          else begin mstack.push_back(npc); npc = t; end
      12: if (mstack.size() == 0) msund = 1;
          else npc = mstack.pop_back();
      13, 14: mill = 1;
      default: ;
    endcase
    if (wr) begin
      mz = (res == 0);
      if (a2 < NUM_REGS) mr[a2] = res;
    end
    mpc = npc;
    mphase = (op == 15) ? 2 : 0;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) model_reset();
    else if (enable) begin
      if (mphase == 0) begin
        if (instr_valid) begin mir = rom[mpc]; mphase = 1; end
      end else if (mphase == 1) model_exec();
    end
  end

  // Compare process: every cycle, on the falling edge
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("cyc_instr_req", int'(instr_req), int'(mphase == 0));
      check("cyc_halted", int'(halted), int'(mphase == 2));
      check("cyc_pc", int'(instruction_pointer), mpc);
      check("cyc_dout", int'(reg_dout), mr[NUM_REGS-1]);
      check("cyc_gout", int'(reg_gout), mr[NUM_REGS-2]);
      check("cyc_flag", int'(reg_flag), mz | (mc << 1) | (msovf << 2) | (msund << 3) | (mill << 4));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0; enable = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // n cycles; toggle=1 enables only every other cycle
  task automatic run(input int n, input bit valid, input bit toggle);
    for (int i = 0; i < n; i++) begin
      instr_valid = valid;
      enable = toggle ? ((i % 2) == 0) : 1'b1;
      @(negedge clk);
    end
  endtask

  // ---------------- directed programs ----------------
  initial begin
    clear_rom();

    // Program A: MOV / ADD / HALT
    rom[0] = enc(1, 0, 0, 5, 15, 0);
    rom[1] = enc(2, 0, 1, 3, 15, 0);
    rom[2] = enc(15, 0, 0, 0, 0, 0);
    do_reset();
    check("rst_req", int'(instr_req), 1);
    check("rst_pc", int'(instruction_pointer), 0);
    check("rst_dout", int'(reg_dout), 0);
    check("rst_flag", int'(reg_flag), 0);
    run(4, 1, 0);
    check("a_dout", int'(reg_dout), 8);
    check("a_pc", int'(instruction_pointer), 2);
    check("a_flag", int'(reg_flag), 0);
    run(2, 1, 0);
    check("a_halted", int'(halted), 1);
    check("a_halt_req", int'(instr_req), 0);
    run(3, 1, 0);
    check("a_pc_frozen", int'(instruction_pointer), 3);

    // Program B: arithmetic, logic, operand sources, ignored write
    clear_rom();
    rom[0]  = enc(1, 0, 0, 8'hFF, 15, 0);
    rom[1]  = enc(2, 0, 1, 1, 15, 0);
    rom[2]  = enc(3, 0, 1, 1, 15, 0);
    rom[3]  = enc(6, 1, 0, 15, 14, 0);
    rom[4]  = enc(7, 0, 1, 0, 14, 0);
    rom[5]  = enc(4, 0, 1, 0, 14, 0);
    rom[6]  = enc(1, 1, 0, 8'hFF, 15, 0);
    rom[7]  = enc(1, 1, 0, 8'hFE, 14, 0);
    rom[8]  = enc(1, 1, 0, 20, 15, 0);
    rom[9]  = enc(1, 0, 0, 7, 200, 0);
    rom[10] = enc(5, 0, 1, 8'h80, 15, 0);
    rom[11] = enc(15, 0, 0, 0, 0, 0);
    do_reset();
    run(4, 1, 0);
    check("b_add_wrap", int'(reg_dout), 0);
    check("b_add_flags", int'(reg_flag), 8'h03);
    run(2, 1, 0);
    check("b_sub_borrow", int'(reg_dout), 8'hFF);
    check("b_sub_flags", int'(reg_flag), 8'h02);
    run(4, 1, 0);
    check("b_shl", int'(reg_gout), 8'hE2);
    run(2, 1, 0);
    check("b_and_zero_flags", int'(reg_flag), 8'h03);
    run(4, 1, 0);
    check("b_din", int'(reg_dout), 8'h5A);
    check("b_gpi", int'(reg_gout), 8'h0A);
    run(4, 1, 0);
    check("b_ignored_wr", int'(reg_dout), 0);
    check("b_ignored_flags", int'(reg_flag), 8'h02);
    run(4, 1, 0);
    check("b_or", int'(reg_dout), 8'h80);
    check("b_halted", int'(halted), 1);

    // Asynchronous reset mid-FETCH, during a stall
    do_reset();
    run(6, 1, 0);
    run(1, 0, 0);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_pc", int'(instruction_pointer), 0);
    check("arst_req", int'(instr_req), 1);
    check("arst_dout", int'(reg_dout), 0);
    check("arst_flag", int'(reg_flag), 0);
    check("arst_halted", int'(halted), 0);
    @(negedge clk);
    resetn = 1'b1;
    run(2, 1, 0);
    check("arst_restart", int'(reg_dout), 8'hFF);

    // Program C: stalled fetch
    clear_rom();
    rom[0] = enc(1, 0, 0, 9, 15, 0);
    rom[1] = enc(15, 0, 0, 0, 0, 0);
    do_reset();
    run(3, 0, 0);
    check("c_stall_req", int'(instr_req), 1);
    check("c_stall_pc", int'(instruction_pointer), 0);
    check("c_stall_dout", int'(reg_dout), 0);
    run(2, 1, 0);
    check("c_mov_done", int'(reg_dout), 9);
    check("c_pc", int'(instruction_pointer), 1);

    // Program D: CALL/RET, stack overflow and underflow, illegal opcode
    clear_rom();
    rom[0]     = enc(8, 0, 0, 0, 0, 3);
    rom[3]     = enc(11, 0, 0, 0, 0, 8'h10);
    rom[8'h10] = enc(12, 0, 0, 0, 0, 0);
    rom[4]     = enc(11, 0, 0, 0, 0, 8'h20);
    rom[8'h20] = enc(11, 0, 0, 0, 0, 8'h30);
    rom[8'h30] = enc(11, 0, 0, 0, 0, 8'h40);
    rom[8'h40] = enc(11, 0, 0, 0, 0, 8'h50);
    rom[8'h50] = enc(11, 0, 0, 0, 0, 8'h60);
    rom[8'h51] = enc(12, 0, 0, 0, 0, 0);
    rom[8'h41] = enc(12, 0, 0, 0, 0, 0);
    rom[8'h31] = enc(12, 0, 0, 0, 0, 0);
    rom[8'h21] = enc(12, 0, 0, 0, 0, 0);
    rom[5]     = enc(12, 0, 0, 0, 0, 0);
    rom[6]     = enc(13, 0, 0, 0, 0, 0);
    rom[7]     = enc(15, 0, 0, 0, 0, 0);
    do_reset();
    run(2, 1, 0);
    check("d_jmp", int'(instruction_pointer), 3);
    run(2, 1, 0);
    check("d_call", int'(instruction_pointer), 8'h10);
    run(2, 1, 0);
    check("d_ret", int'(instruction_pointer), 4);
    run(10, 1, 0);
    check("d_sovf_pc", int'(instruction_pointer), 8'h51);
    check("d_sovf_flag", int'(reg_flag), 8'h04);
    run(18, 1, 0);
    check("d_end_flags", int'(reg_flag), 8'h1C);
    check("d_end_pc", int'(instruction_pointer), 8);
    check("d_end_halted", int'(halted), 1);

    // Program E: BZ/BNZ loop, full rate then half rate
    clear_rom();
    rom[0] = enc(1, 0, 0, 3, 15, 0);
    rom[1] = enc(3, 0, 1, 1, 15, 0);
    rom[2] = enc(10, 1, 0, 15, 0, 1);
    rom[3] = enc(9, 1, 0, 15, 0, 5);
    rom[4] = enc(1, 0, 0, 8'hEE, 15, 0);
    rom[5] = enc(1, 0, 0, 8'h42, 14, 0);
    rom[6] = enc(15, 0, 0, 0, 0, 0);
    do_reset();
    run(20, 1, 0);
    check("e_full_halted", int'(halted), 1);
    check("e_full_dout", int'(reg_dout), 0);
    check("e_full_gout", int'(reg_gout), 8'h42);
    check("e_full_pc", int'(instruction_pointer), 7);
    do_reset();
    run(38, 1, 1);
    check("e_half_not_yet", int'(halted), 0);
    run(2, 1, 1);
    check("e_half_halted", int'(halted), 1);
    check("e_half_dout", int'(reg_dout), 0);
    check("e_half_gout", int'(reg_gout), 8'h42);
    check("e_half_pc", int'(instruction_pointer), 7);
    check("e_half_flag", int'(reg_flag), 0);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
- Parametrised successor to the single-cycle 8-bit cpu: generic data width, register count, and call-stack depth.
- Two-state fetch/execute FSM with a request/valid handshake to instruction memory, so instruction ROM/RAM may stall.
- Adds CALL/RET with a hardware return stack, carry/zero flags, sticky error flags and HALT.
- Sits at the top of the datapath; instruction memory is external.

Parameters:
DATA_W, 8, datapath/register width (>= 8)
ADDR_W, 8, instruction address width (<= 8)
NUM_REGS, 16, general registers R0..R(NUM_REGS-1) (>= 2, <= 254)
STACK_DEPTH, 4, return-stack entries (>= 1)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  advance FSM; low freezes all state
instr_req  output  1  fetch request
instr_valid  input  1  instruction bus valid this cycle
instruction  input  32  instruction word
instruction_pointer  output  ADDR_W  fetch address (PC)
din  input  DATA_W  data input, read as register index 8'hFF
gpi  input  4  general input, read as index 8'hFE (zero-extended)
reg_dout  output  DATA_W  mirror of R(NUM_REGS-1)
reg_gout  output  DATA_W  mirror of R(NUM_REGS-2)
reg_flag  output  8  flags register
halted  output  1  high in HALT state

Behaviour:
- Encoding: [31:28] opcode, [27] a_is_reg, [26] b_is_reg, [25:24] ignored, [23:16] arg1, [15:8] arg2 (also destination index), [7:0] target address (low ADDR_W bits).
- Operand A = a_is_reg ? read(arg1) : zext(arg1); B likewise with arg2.
- read(i): R[i] if i < NUM_REGS; din if 8'hFF; zext(gpi) if 8'hFE; otherwise 0.
- Writes to indices >= NUM_REGS are ignored.
- Opcodes:
  - 0 NOP
  - 1 MOV: R[arg2] <= A
  - 2 ADD: R[arg2] <= A+B, C = carry out
  - 3 SUB: R[arg2] <= B-A, C = borrow
  - 4 AND, 5 OR, 6 XOR: R[arg2] <= B op A, C unchanged
  - 7 SHL: R[arg2] <= B<<1, C = B msb
  - 8 JMP
  - 9 BZ: branch if A==0
  - 10 BNZ: branch if A!=0
  - 11 CALL
  - 12 RET
  - 15 HALT
  - 13, 14 illegal: execute as NOP and set ILL.
- All arithmetic is mod 2^DATA_W.
- reg_flag: bit0 Z, bit1 C, bit2 SOVF, bit3 SUND, bit4 ILL, bits7:5 = 0.
  - Z and C are updated only by opcodes 1-7; Z = (result == 0); MOV/logic ops leave C unchanged.
  - SOVF, SUND and ILL are sticky until reset.
- FSM FETCH:
  - instr_req=1 with instruction_pointer=PC.
  - On instr_valid&&enable, latch the instruction into IR and go to EXEC.
  - Otherwise hold; instr_req stays high.
- FSM EXEC (instr_req=0):
  - Perform the writeback and flag update.
  - Next PC = target on taken JMP/BZ/BNZ/CALL; stack top on RET; else PC+1 (wraps to 0).
  - Next state FETCH, or HALT on opcode 15.
- Latency: 2 enabled cycles per instruction when instr_valid is immediate; each stall cycle adds 1.
- CALL pushes PC+1, then jumps.
  - If the stack is full (STACK_DEPTH entries): set SOVF, do not push, PC+1.
- RET pops into PC.
  - If the stack is empty: set SUND, PC+1.
- HALT: absorbing until reset; halted=1, instr_req=0, no writes.
- enable=0: no state, PC, register, flag or stack change; instr_valid is ignored that cycle.
- Reset (asynchronous, any time, including mid-stall): PC=0, state=FETCH, all R=0, flags=0, stack empty, halted=0.
  - instr_req=1 after reset is released.
  - reg_dout and reg_gout read 0.

Test Plan:
- Reset, always-valid ROM: MOV #5->R15; ADD #3,R15 (b_is_reg) -> reg_dout=8 after 4 enabled cycles; PC=2; flags=0.
- ADD #1 to R0=0xFF (DATA_W=8) -> R0=0x00, Z=1, C=1. Then SUB #1 from R0 -> 0xFF, C=1 (borrow), Z=0.
- Hold instr_valid low 3 cycles at PC=0 -> instr_req stays 1, PC stays 0, no register change; 5 cycles to complete MOV.
- CALL 0x10 at PC=3; RET at 0x10 -> PC sequence 3,0x10,4. With STACK_DEPTH=4, 5 nested CALLs -> 5th sets reg_flag[2] and continues at PC+1. RET on empty stack -> reg_flag[3]=1.
- Opcode 13 -> reg_flag[4]=1, PC+1. HALT -> halted=1, instr_req=0, PC frozen. resetn low mid-FETCH -> all outputs to reset values immediately.
- enable toggled 1/0 per cycle -> results identical to the enable=1 run, at half rate.
